// File: rtl/serial_pattern_tx_if.sv
// Bundle of the transmit request and serial output signals of serial_pattern_tx.
// The master side issues transmissions and watches the line; the slave side is the transmitter.
interface serial_pattern_tx_if #(
  parameter int W     = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic [W-1:0]     pattern;
  logic [CNT_W-1:0] reps;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, pattern, reps,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter.
// Latches a W-bit pattern and a repeat count when a start is accepted.
// Sends the pattern MSB-first, one bit per clock, with the copies back-to-back.
// All outputs come straight from registers.
module serial_pattern_tx #(
  parameter int W        = 4,
  parameter int CNT_W    = 4,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_pattern_tx_if.slave    bus
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0]    BIT_MAX = BW'(W - 1);
  localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FINISH
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_pattern;
  logic [W-1:0]     r_shreg;
  logic [CNT_W-1:0] r_repCnt;
  logic [BW-1:0]    r_bitCnt;
  logic             r_dout;
  logic             r_doutValid;
  logic             r_busy;
  logic             r_done;

  // r_shreg holds the bits still to be sent in the current copy, so the bit on
  // dout is already the registered output and the line needs no extra mux stage.
  // FINISH shares the accept path with IDLE so a held start launches the next
  // transmission right after the single FINISH cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_pattern   <= '0;
      r_shreg     <= '0;
      r_repCnt    <= '0;
      r_bitCnt    <= '0;
      r_dout      <= IDLE_BIT;
      r_doutValid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FINISH: begin
          r_state     <= IDLE;
          r_dout      <= IDLE_BIT;
          r_doutValid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          if (bus.start) begin
            r_pattern <= bus.pattern;
            r_repCnt  <= bus.reps;
            r_bitCnt  <= BIT_MAX;
            if (bus.reps != '0) begin
              r_state     <= SEND;
              r_shreg     <= bus.pattern << 1;
              r_dout      <= bus.pattern[W-1];
              r_doutValid <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_state <= FINISH;
              r_shreg <= bus.pattern;
              r_done  <= 1'b1;
            end
          end
        end

        SEND: begin
          if (r_bitCnt != '0) begin
            r_dout   <= r_shreg[W-1];
            r_shreg  <= {r_shreg[W-2:0], 1'b0};
            r_bitCnt <= r_bitCnt - 1'b1;
          end else if (r_repCnt > REP_ONE) begin
            r_dout   <= r_pattern[W-1];
            r_shreg  <= r_pattern << 1;
            r_bitCnt <= BIT_MAX;
            r_repCnt <= r_repCnt - 1'b1;
          end else begin
            r_state     <= FINISH;
            r_dout      <= IDLE_BIT;
            r_doutValid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_dout      <= IDLE_BIT;
          r_doutValid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_doutValid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx with W=4, CNT_W=4, IDLE_BIT=0.
// Observed vector is {dout, dout_valid, busy, done}, sampled on the falling edge.
module tb_serial_pattern_tx;

  logic clk;
  logic reset;
  int   nCompared;
  int   nMismatched;
  int   hits;

  serial_pattern_tx_if #(.W(4), .CNT_W(4)) bus ();

  serial_pattern_tx #(.W(4), .CNT_W(4), .IDLE_BIT(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] obs;
  assign obs = {bus.dout, bus.dout_valid, bus.busy, bus.done};

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something keeps the bench from reaching its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected summary");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents a start for one edge, then scrambles the inputs to prove they were latched.
  // Returns at the falling edge of the first cycle after the accepting edge.
  task automatic applyStimulus(input logic [3:0] pat, input logic [3:0] nReps);
    bus.pattern = pat;
    bus.reps    = nReps;
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.pattern = ~pat;
    bus.reps    = 4'd7;
  endtask

  // Sends one transmission and checks every bit, the done pulse and the quiet cycle after.
  // A stray start can be injected during a chosen bit cycle; hits counts looped-back 1001s.
  task automatic sendAndCheck(input string tag, input logic [3:0] pat,
                              input logic [3:0] nReps, input int glitchCycle,
                              output int nHits);
    logic [3:0] win;
    int         total;
    int         idx;
    win   = '0;
    nHits = 0;
    applyStimulus(pat, nReps);
    total = int'(nReps) * 4;
    for (int c = 0; c < total; c++) begin
      idx = 3 - (c % 4);
      checkOutput($sformatf("%s bit%0d", tag, c), 32'(obs), 32'({pat[idx], 3'b110}));
      if (bus.dout_valid) begin
        win = {win[2:0], bus.dout};
        if (win == 4'b1001) nHits++;
      end
      if (c == glitchCycle) begin
        bus.start   = 1'b1;
        bus.pattern = 4'b1111;
        bus.reps    = 4'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("%s done", tag), 32'(obs), 32'(4'b0001));
    @(negedge clk);
    checkOutput($sformatf("%s after", tag), 32'(obs), 32'(4'b0000));
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.reps    = '0;
    $display("[TB] serial_pattern_tx bench starting");

    // Reset state and 20 quiet cycles with no start.
    repeat (2) @(negedge clk);
    checkOutput("in reset", 32'(obs), 32'(4'b0000));
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle%0d", i), 32'(obs), 32'(4'b0000));
    end

    // Single copy of 1001.
    sendAndCheck("r1", 4'b1001, 4'd1, -1, hits);

    // Two copies of 1001, no gap, looped-back detector sees two hits.
    sendAndCheck("r2", 4'b1001, 4'd2, -1, hits);
    checkOutput("r2 hits", 32'(hits), 32'd2);

    // Zero repeats: done immediately, no valid bits.
    applyStimulus(4'b1010, 4'd0);
    checkOutput("r0 done", 32'(obs), 32'(4'b0001));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("r0 quiet%0d", i), 32'(obs), 32'(4'b0000));
    end

    // Stray start during SEND of a three-copy transmission is ignored.
    sendAndCheck("r3g", 4'b1101, 4'd3, 5, hits);

    // Reset during bit 2 of a three-copy transmission aborts it with no done.
    applyStimulus(4'b1001, 4'd3);
    checkOutput("abort bit0", 32'(obs), 32'(4'b1110));
    @(negedge clk);
    checkOutput("abort bit1", 32'(obs), 32'(4'b0110));
    @(negedge clk);
    checkOutput("abort bit2", 32'(obs), 32'(4'b0110));
    #2 reset = 1'b0;
    #1 checkOutput("abort async", 32'(obs), 32'(4'b0000));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort held%0d", i), 32'(obs), 32'(4'b0000));
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort nodone%0d", i), 32'(obs), 32'(4'b0000));
    end
    sendAndCheck("postrst", 4'b1011, 4'd1, -1, hits);

    // Maximum repeat count: 60 bits of 0110 then one done.
    sendAndCheck("r15", 4'b0110, 4'd15, -1, hits);

    // Start held high: next transmission follows the single FINISH cycle.
    bus.pattern = 4'b1100;
    bus.reps    = 4'd1;
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b a0", 32'(obs), 32'(4'b1110));
    @(negedge clk);
    checkOutput("b2b a1", 32'(obs), 32'(4'b1110));
    @(negedge clk);
    checkOutput("b2b a2", 32'(obs), 32'(4'b0110));
    @(negedge clk);
    checkOutput("b2b a3", 32'(obs), 32'(4'b0110));
    bus.pattern = 4'b0011;
    @(negedge clk);
    checkOutput("b2b finish", 32'(obs), 32'(4'b0001));
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("b2b b0", 32'(obs), 32'(4'b0110));
    @(negedge clk);
    checkOutput("b2b b1", 32'(obs), 32'(4'b0110));
    @(negedge clk);
    checkOutput("b2b b2", 32'(obs), 32'(4'b1110));
    @(negedge clk);
    checkOutput("b2b b3", 32'(obs), 32'(4'b1110));
    @(negedge clk);
    checkOutput("b2b done", 32'(obs), 32'(4'b0001));
    @(negedge clk);
    checkOutput("b2b after", 32'(obs), 32'(4'b0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
